ysyx_22040632_mdu: RTL and testbench
====================================

# ysyx_22040632_mdu

Iterative multiply/divide unit for the ysyx_22040632 core, covering the RV64M subset (including W-forms) at a width set by `XLEN`. It replaces single-cycle `*`, `/` and `%` in the execute stage with a radix-2 shift-add multiplier and a restoring divider that share one FSM. Operation requests arrive through a valid/ready handshake and results return the same way. The execute stage stalls its pipeline on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 64: datapath width; legal values are 32 and 64.
- `TAG_W`, 5: width of the opaque tag, normally the destination register index.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of any in-flight operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request; equals `state==IDLE`.
- `in_op` input 4: operation code (see Operation).
- `in_src1` input XLEN: rs1 operand, dividend or multiplicand.
- `in_src2` input XLEN: rs2 operand, divisor or multiplier.
- `in_tag` input TAG_W: returned unchanged with the result.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output XLEN: result.
- `out_tag` output TAG_W: tag of the result.

## Operation
- Op codes:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - Any other code completes as a fast op with result 0.
  - When XLEN=32, codes 8–15 are undefined.
- Setup on accept: operands are converted to magnitudes and the result sign is registered.
  - Signedness follows the ISA. MULHSU treats src1 as signed and src2 as unsigned.
  - W-forms use src[31:0] only and sign- or zero-extend per op.
- Iteration count N is XLEN for full-width ops and 32 for W-forms.
- Multiply uses a 2·XLEN accumulator with one shift-add per cycle.
  - MUL and MULW take the low half.
  - MULH, MULHSU and MULHU take the high XLEN bits of the signed-corrected product.
- Divide is restoring: one quotient bit per cycle, with partial remainder width XLEN+1.
- Sign correction rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Fast paths (no BUSY cycles):
  - Divide by zero: quotient is all-ones; remainder is the dividend (the 32-bit value sign-extended for W-forms).
  - Signed overflow (most-negative ÷ −1): quotient is the dividend; remainder is 0.
- W-form results are sign-extended from bit 31 to XLEN, including DIVUW and REMUW.
- FSM states and transitions:
  - IDLE → BUSY on accept; IDLE → DONE on accept of a fast op.
  - BUSY → FIX after N iterations.
  - FIX → DONE; sign correction and extension are registered in FIX.
  - DONE → IDLE on `out_valid & out_ready`.
- `flush` from any state goes to IDLE. A request presented in the same cycle as `flush` is not accepted.
- Reset values:
  - state is IDLE; `in_ready`=1; `out_valid`=0.
  - `out_data`=0 and `out_tag`=0.
  - Iteration counter and accumulators are 0.

## Timing
- Accept happens in cycle 0, when `in_valid & in_ready` is sampled at the edge.
- Normal op: BUSY in cycles 1..N, FIX in cycle N+1, `out_valid` first high in cycle N+2.
  - Full-width at XLEN=64: 66 cycles to `out_valid`.
  - W-form: 34 cycles to `out_valid`.
- Fast op: `out_valid` high in cycle 1.
- `out_data` and `out_tag` are stable while `out_valid & !out_ready`, for any number of cycles.
- No back-to-back acceptance: `in_ready` returns to 1 in the cycle after the result handshake.
  - Minimum spacing between accepts is therefore N+3 cycles for normal ops and 2 cycles for fast ops.
- `flush` in cycle k forces `out_valid`=0 and `in_ready`=1 in cycle k+1. Internal datapath registers need not be cleared.
- Reset asserted mid-operation drops `out_valid` immediately (asynchronously). No result is produced after release.

## Test plan
- MUL, src1=7, src2=0xFFFF_FFFF_FFFF_FFFD, tag=3 → `out_data`=0xFFFF_FFFF_FFFF_FFEB, `out_tag`=3, `out_valid` exactly 66 cycles after accept.
- MULHU with both operands all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0. MULHSU with src1=−1, src2=2 → all-ones.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM −7%2 → all-ones (−1). DIVUW 100/7 → 14, arriving 34 cycles after accept.
- Fast paths, each with `out_valid` in cycle 1:
  - DIVU 5/0 → all-ones.
  - REMU 5/0 → 5.
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000.
  - DIVW of src1=0x0000_0001_8000_0000 by −1 → 0xFFFF_FFFF_8000_0000.
- Backpressure: hold `out_ready` low for 10 cycles after `out_valid` → data and tag unchanged, `in_ready`=0 throughout. Raise `out_ready` → `in_ready`=1 the next cycle.
- Flush and reset:
  - Assert `flush` in BUSY cycle 20 → no `out_valid` ever appears; a new MUL 3×4 accepted afterwards returns 12.
  - Drop `rst_n` mid-BUSY → all outputs at their reset values during reset.

Source files
------------

// File: rtl/ysyx_22040632_mdu.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one accumulator and one FSM, with valid/ready on both sides.
module ysyx_22040632_mdu #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned WSH   = XLEN - 32;
    localparam logic        HAS_W = (XLEN == 64);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd12,
        OP_DIVUW  = 4'd13,
        OP_REMW   = 4'd14,
        OP_REMUW  = 4'd15
    } op_e;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   mplr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_last;
    logic              r_div, r_rem, r_hi, r_w, r_neg_q, r_neg_r;

    logic              accept;
    logic              d_valid, d_s1, d_s2, d_w, d_div, d_rem, d_hi;
    logic [XLEN-1:0]   a_ext, b_ext, dvd_sx, mag_a, mag_b;
    logic              a_neg, b_neg, div0, ovf, fast;
    logic [XLEN-1:0]   fast_data;

    logic [XLEN:0]     rs;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   q_s, r_s, sel;
    logic [XLEN-1:0]   fix_data;

    // ---------------------------------------------------------------- decode
    always_comb begin
        d_valid = 1'b0;
        d_s1    = 1'b0;
        d_s2    = 1'b0;
        case (in_op)
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: d_valid = 1'b1;
            OP_MULH, OP_DIV, OP_REM: begin
                d_valid = 1'b1;
                d_s1    = 1'b1;
                d_s2    = 1'b1;
            end
            OP_MULHSU: begin
                d_valid = 1'b1;
                d_s1    = 1'b1;
            end
            OP_MULW, OP_DIVUW, OP_REMUW: d_valid = HAS_W;
            OP_DIVW, OP_REMW: begin
                d_valid = HAS_W;
                d_s1    = HAS_W;
                d_s2    = HAS_W;
            end
            default: ;
        endcase
    end

    assign d_w   = in_op[3] & HAS_W;
    assign d_div = in_op[2];
    assign d_rem = in_op[1];
    assign d_hi  = (in_op[1:0] != 2'b00) & ~in_op[3];

    always_comb begin
        a_ext  = in_src1;
        b_ext  = in_src2;
        dvd_sx = in_src1;
        if (d_w) begin
            a_ext  = d_s1 ? XLEN'($signed(in_src1[31:0])) : XLEN'(in_src1[31:0]);
            b_ext  = d_s2 ? XLEN'($signed(in_src2[31:0])) : XLEN'(in_src2[31:0]);
            dvd_sx = XLEN'($signed(in_src1[31:0]));
        end
    end

    assign a_neg = d_s1 & a_ext[XLEN-1];
    assign b_neg = d_s2 & b_ext[XLEN-1];
    assign mag_a = a_neg ? -a_ext : a_ext;
    assign mag_b = b_neg ? -b_ext : b_ext;

    assign div0 = (b_ext == '0);
    assign ovf  = d_s1 & (b_ext == '1) &
                  (d_w ? (in_src1[31:0] == 32'h8000_0000) : (in_src1 == XMIN));
    assign fast = ~d_valid | (d_div & (div0 | ovf));

    always_comb begin
        fast_data = '0;
        if (d_valid && div0)
            fast_data = d_rem ? dvd_sx : '1;
        else if (d_valid)
            fast_data = d_rem ? '0 : dvd_sx;
    end

    assign accept = in_valid & (state == IDLE) & ~flush;

    // ------------------------------------------------------------- iteration
    // Division keeps {remainder, quotient/dividend} in acc; the top XLEN+1 bits
    // after a 1-bit left shift form the trial partial remainder.
    assign rs   = acc[2*XLEN-1:XLEN-1];
    assign diff = rs[XLEN-1:0] - opb;

    always_comb begin
        if (r_div) begin
            if (rs >= {1'b0, opb})
                acc_nxt = {diff, acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_nxt = {acc[2*XLEN-2:0], 1'b0} +
                      (mplr[XLEN-1] ? {{XLEN{1'b0}}, opb} : '0);
        end
    end

    assign cnt_last = r_w ? CNT_W'(31) : CNT_W'(XLEN - 1);

    // ------------------------------------------------------- sign correction
    assign prod_s = r_neg_q ? -acc : acc;
    assign q_s    = r_neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign r_s    = r_neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        if (r_div)
            sel = r_rem ? r_s : q_s;
        else
            sel = r_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        fix_data = r_w ? XLEN'($signed(sel[31:0])) : sel;
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = fast ? DONE : BUSY;
                BUSY: if (cnt == cnt_last) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opb      <= '0;
            mplr     <= '0;
            cnt      <= '0;
            r_div    <= 1'b0;
            r_rem    <= 1'b0;
            r_hi     <= 1'b0;
            r_w      <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        cnt     <= '0;
                        r_div   <= d_div;
                        r_rem   <= d_rem;
                        r_hi    <= d_hi;
                        r_w     <= d_w;
                        r_neg_q <= a_neg ^ b_neg;
                        r_neg_r <= a_neg;
                        // W-forms pre-shift so 32 iterations consume the live bits
                        opb     <= d_div ? mag_b : mag_a;
                        mplr    <= d_w ? (mag_b << WSH) : mag_b;
                        acc     <= d_div ? {{XLEN{1'b0}}, (d_w ? (mag_a << WSH) : mag_a)} : '0;
                        if (fast)
                            out_data <= fast_data;
                    end
                end
                BUSY: begin
                    cnt  <= cnt + CNT_W'(1);
                    acc  <= acc_nxt;
                    mplr <= {mplr[XLEN-2:0], 1'b0};
                end
                FIX: out_data <= fix_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_mdu.sv
// Self-checking bench for ysyx_22040632_mdu (XLEN=64): directed vectors, latency,
// backpressure, flush and reset, then random ops against an arithmetic model.
module tb_ysyx_22040632_mdu;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [63:0] in_src1 = '0;
    logic [63:0] in_src2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_tag;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_22040632_mdu #(.XLEN(64), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference results straight from the RV64M definitions.
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        logic signed [63:0]  s1, s2;
        logic signed [31:0]  w1, w2;
        logic [31:0]         u1, u2, r32;
        logic [63:0]         r;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        s1 = a;
        s2 = b;
        u1 = a[31:0];
        u2 = b[31:0];
        w1 = u1;
        w2 = u2;
        r   = '0;
        r32 = '0;
        p   = '0;
        case (op)
            4'd0: r = a * b;
            4'd1: begin p = sa * sb; r = p[127:64]; end
            4'd2: begin p = sa * ub; r = p[127:64]; end
            4'd3: begin p = ua * ub; r = p[127:64]; end
            4'd4: begin
                if (b == '0) r = '1;
                else if (a == MIN64 && b == '1) r = a;
                else r = s1 / s2;
            end
            4'd5: r = (b == '0) ? '1 : a / b;
            4'd6: begin
                if (b == '0) r = a;
                else if (a == MIN64 && b == '1) r = '0;
                else r = s1 % s2;
            end
            4'd7: r = (b == '0) ? a : a % b;
            4'd8: begin r32 = u1 * u2; r = sx32(r32); end
            4'd12: begin
                if (u2 == '0) r32 = '1;
                else if (u1 == 32'h8000_0000 && u2 == '1) r32 = u1;
                else r32 = w1 / w2;
                r = sx32(r32);
            end
            4'd13: begin r32 = (u2 == '0) ? '1 : u1 / u2; r = sx32(r32); end
            4'd14: begin
                if (u2 == '0) r32 = u1;
                else if (u1 == 32'h8000_0000 && u2 == '1) r32 = '0;
                else r32 = w1 % w2;
                r = sx32(r32);
            end
            4'd15: begin r32 = (u2 == '0) ? u1 : u1 % u2; r = sx32(r32); end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle (accept = cycle 0) in which out_valid is first expected.
    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return 66;
            4'd8: return 34;
            4'd4, 4'd6: return (b == '0 || (a == MIN64 && b == '1)) ? 1 : 66;
            4'd5, 4'd7: return (b == '0) ? 1 : 66;
            4'd12, 4'd14:
                return (b[31:0] == '0 || (a[31:0] == 32'h8000_0000 && b[31:0] == '1)) ? 1 : 34;
            4'd13, 4'd15: return (b[31:0] == '0) ? 1 : 34;
            default: return 1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input logic [63:0] exp_data,
                          input int exp_lat, input int hold, input string name);
        int lat;
        @(negedge clk);
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_src1  = {$urandom, $urandom};
        in_src2  = {$urandom, $urandom};
        in_tag   = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " data"}, out_data, exp_data);
        check({name, " tag"}, 64'(out_tag), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold valid"}, 64'(out_valid), 64'd1);
            check({name, " hold data"}, out_data, exp_data);
            check({name, " hold tag"}, 64'(out_tag), 64'(tag));
            check({name, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " ready after handshake"}, 64'(in_ready), 64'd1);
        check({name, " valid after handshake"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb;
        logic [3:0]  ops [16];
        logic [3:0]  op;
        int          seen;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                4'd8, 4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd11};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", out_data, 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, "MUL");
        run_op(4'd3, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, "MULHU");
        run_op(4'd1, '1, '1, 5'd5, 64'd0, 66, 0, "MULH");
        run_op(4'd2, '1, 64'd2, 5'd6, '1, 66, 0, "MULHSU");
        run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, "DIV");
        run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, '1, 66, 0, "REM");
        run_op(4'd13, 64'd100, 64'd7, 5'd9, 64'd14, 34, 0, "DIVUW");
        run_op(4'd5, 64'd5, 64'd0, 5'd10, '1, 1, 0, "DIVU by 0");
        run_op(4'd7, 64'd5, 64'd0, 5'd11, 64'd5, 1, 0, "REMU by 0");
        run_op(4'd4, MIN64, '1, 5'd12, MIN64, 1, 0, "DIV overflow");
        run_op(4'd12, 64'h0000_0001_8000_0000, '1, 5'd13, 64'hFFFF_FFFF_8000_0000, 1, 0, "DIVW overflow");
        run_op(4'd5, 64'd1000, 64'd9, 5'd14, 64'd111, 66, 10, "backpressure");

        // flush during BUSY cycle 20, with a competing request in the same cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_src1  = 64'd123;
        in_src2  = 64'd456;
        in_tag   = 5'd21;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd9;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush no result", 64'(seen), 64'd0);
        run_op(4'd0, 64'd3, 64'd4, 5'd22, 64'd12, 66, 0, "MUL after flush");

        // reset mid-BUSY
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd4;
        in_src1  = 64'd999;
        in_src2  = 64'd3;
        in_tag   = 5'd23;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset out_data", out_data, 64'd0);
        check("midreset out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midreset no result", 64'(seen), 64'd0);

        // random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 15)];
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = ($urandom_range(0, 1) != 0) ? MIN64 : {$urandom, 32'h8000_0000}; rb = '1; end
                2: begin
                    ra = 64'($urandom_range(0, 1000));
                    rb = 64'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) != 0) rb = -rb;
                end
                3: begin
                    ra = -64'($urandom_range(0, 1000));
                    rb = 64'($urandom_range(1, 20));
                end
                4: rb = {32'd0, $urandom};
                default: ;
            endcase
            run_op(op, ra, rb, 5'($urandom), ref_res(op, ra, rb), ref_lat(op, ra, rb),
                   $urandom_range(0, 2), $sformatf("rand%0d op%0d", n, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
